striping: RTL and testbench

//  - Transmit-side byte striper of the 2-lane PHY: splits one byte stream at clk_2f rate into lane_0/lane_1.
//  - Each lane is updated at clk_f rate, using an internal frame phase in the clk_2f domain.
//  - Sits after the TX source and drives the lanes consumed by the RX unstriping block.
//  - Lane order is strictly alternating over valid bytes: first valid byte after reset -> lane 0, next -> lane 1, ...

---
 rtl/phy_pkg.sv | 7 +
 rtl/striping.sv | 65 ++++++
 tb/tb_striping.sv | 125 ++++++++++++
 3 files changed

// File: rtl/phy_pkg.sv
// phy_pkg: constants shared by the 2-lane PHY striping and unstriping blocks.
package phy_pkg;
  localparam int DATA_W = 8;
  localparam logic [7:0] IDLE_BYTE = 8'hBC;
  localparam int LANE0 = 0;
  localparam int LANE1 = 1;
endpackage

// File: rtl/striping.sv
// striping: splits a clk_2f byte stream alternately onto two lanes updated once per frame.
// Define STRIPING_IDLE_EN to fill byte-less lanes with IDLE_BYTE instead of holding the last byte.
module striping
  import phy_pkg::*;
#(
  parameter int DATA_W = phy_pkg::DATA_W,
  parameter logic [7:0] IDLE_BYTE = phy_pkg::IDLE_BYTE
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic [DATA_W-1:0] lane_0,
  output logic              valid_0,
  output logic [DATA_W-1:0] lane_1,
  output logic              valid_1
);
`ifdef STRIPING_IDLE_EN
  localparam bit IDLE_EN = 1'b1;
`else
  localparam bit IDLE_EN = 1'b0;
`endif
  localparam logic [DATA_W-1:0] FILL = DATA_W'(IDLE_BYTE);
  logic phase_q, sel_q, sel_d;
  logic [1:0] stv_q, stv_d, stv_n;
  logic [1:0][DATA_W-1:0] st_q, st_d;
  logic [DATA_W-1:0] lane_0_d, lane_1_d;
  logic valid_0_d, valid_1_d;
  // stv_n/st_d include the byte accepted on this edge so a frame end can emit it immediately
  always_comb begin
    st_d = st_q;
    stv_n = stv_q;
    sel_d = sel_q ^ valid_in;
    if (valid_in) begin
      st_d[sel_q] = data_in;
      stv_n[sel_q] = 1'b1;
    end
    stv_d = phase_q ? 2'b00 : stv_n;
    lane_0_d = !phase_q ? lane_0 : stv_n[LANE0] ? st_d[LANE0] : IDLE_EN ? FILL : lane_0;
    lane_1_d = !phase_q ? lane_1 : stv_n[LANE1] ? st_d[LANE1] : IDLE_EN ? FILL : lane_1;
    valid_0_d = phase_q ? stv_n[LANE0] : valid_0;
    valid_1_d = phase_q ? stv_n[LANE1] : valid_1;
  end
  always_ff @(posedge clk_2f) begin
    if (!reset) begin
      phase_q <= 1'b0;
      sel_q <= 1'b0;
      stv_q <= '0;
      st_q <= '0;
      lane_0 <= '0;
      lane_1 <= '0;
      valid_0 <= 1'b0;
      valid_1 <= 1'b0;
    end else begin
      phase_q <= ~phase_q;
      sel_q <= sel_d;
      stv_q <= stv_d;
      st_q <= st_d;
      lane_0 <= lane_0_d;
      lane_1 <= lane_1_d;
      valid_0 <= valid_0_d;
      valid_1 <= valid_1_d;
    end
  end
endmodule

// File: tb/tb_striping.sv
// tb_striping: directed and random stimulus against a frame-level model plus an in-bench unstriper.
module tb_striping;
`ifdef STRIPING_IDLE_EN
  localparam bit IDLE_EN = 1'b1;
`else
  localparam bit IDLE_EN = 1'b0;
`endif
  logic clk_2f = 1'b0;
  logic reset = 1'b0;
  logic valid_in = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] lane_0, lane_1;
  logic valid_0, valid_1;
  int total = 0;
  int bad = 0;
  bit mph;
  int mcnt, rxc;
  logic [7:0] fb[2];
  bit fv[2];
  logic [7:0] el[2];
  bit ev[2];
  logic [7:0] inq[$];
  striping dut (
    .clk_2f(clk_2f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .lane_0(lane_0), .valid_0(valid_0), .lane_1(lane_1), .valid_1(valid_1)
  );
  always #5 clk_2f = ~clk_2f;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic unstripe();
    logic [7:0] lo[2];
    bit vo[2];
    int first;
    lo[0] = lane_0; lo[1] = lane_1;
    vo[0] = valid_0; vo[1] = valid_1;
    first = rxc % 2;
    for (int k = 0; k < 2; k++) begin
      int ln;
      ln = (first + k) % 2;
      if (vo[ln]) begin
        if (inq.size() == 0) chk("rx_extra", 1, 0);
        else chk("rx_seq", lo[ln], inq.pop_front());
        rxc++;
      end
    end
  endtask
  task automatic step(input bit r, input bit v, input logic [7:0] d);
    bit fe;
    reset = r; valid_in = v; data_in = d;
    @(posedge clk_2f);
    fe = r && mph;
    if (!r) begin
      mph = 0; mcnt = 0; rxc = 0;
      fv = '{0, 0}; el = '{8'h00, 8'h00}; ev = '{0, 0};
      inq.delete();
    end else begin
      if (v) begin
        fb[mcnt % 2] = d;
        fv[mcnt % 2] = 1;
        mcnt++;
        inq.push_back(d);
      end
      if (mph) begin
        for (int k = 0; k < 2; k++) begin
          ev[k] = fv[k];
          el[k] = fv[k] ? fb[k] : (IDLE_EN ? 8'hBC : el[k]);
        end
        fv = '{0, 0};
      end
      mph = ~mph;
    end
    #1;
    chk("lane_0", lane_0, el[0]);
    chk("valid_0", valid_0, ev[0]);
    chk("lane_1", lane_1, el[1]);
    chk("valid_1", valid_1, ev[1]);
    if (fe) unstripe();
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 8'h00);
  endtask
  task automatic align0();
    if (mph) idle(1);
  endtask
  initial begin
    int sent;
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00);
    step(1, 1, 8'h11);
    step(1, 1, 8'h22);
    step(1, 1, 8'h33);
    step(1, 1, 8'h44);
    idle(2);
    align0();
    step(1, 1, 8'hA5);
    idle(7);
    step(1, 1, 8'h5A);
    idle(3);
    if (!mph) idle(1);
    step(1, 1, 8'h01);
    step(1, 1, 8'h02);
    idle(4);
    align0();
    step(1, 1, 8'h77);
    step(0, 0, 8'h00);
    step(1, 1, 8'h66);
    idle(3);
    chk("after_rst_lane1", lane_1, 8'h00);
    sent = 0;
    while (sent < 256) begin
      bit v;
      v = ($urandom_range(0, 2) != 0);
      step(1, v, 8'($urandom));
      if (v) sent++;
    end
    idle(4);
    chk("rx_drain", inq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
